axil_master_q: RTL and testbench
================================

# axil_master_q

Parametrised AXI4-Lite master bridge with a queued local request port. Local requests (read or write) are buffered in a DEPTH-entry command FIFO and issued one at a time on the AXI4-Lite channels. Each completed transaction returns through a valid/ready response port carrying read data and the response code. It sits between local bus initiators and the AXI4-Lite interconnect and adds configurable widths, buffering, backpressure and an optional response watchdog.

## Interface
- ADDR_W, 32, address width (AWADDR/ARADDR/BUS_REQ_ADDR)
- DATA_W, 32, data width; 32 or 64 only
- DEPTH, 4, command FIFO entries; power of 2, >= 2
- TIMEOUT_CYC, 1024, response watchdog limit in cycles (used only with AXIL_MASTER_TIMEOUT_EN)
- PROT, 3'b000, constant driven on AWPROT/ARPROT

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  synchronous reset, active-high
- AWADDR/AWPROT/AWVALID out ADDR_W/3/1, AWREADY in 1  write address channel
- WDATA/WSTRB/WVALID out DATA_W/DATA_W/8/1, WREADY in 1  write data channel
- BVALID in 1, BRESP in 2, BREADY out 1  write response channel
- ARADDR/ARPROT/ARVALID out ADDR_W/3/1, ARREADY in 1  read address channel
- RDATA in DATA_W, RRESP in 2, RVALID in 1, RREADY out 1  read data channel
- BUS_REQ_VALID  in  1  request present
- BUS_REQ_READY  out  1  FIFO can accept
- BUS_REQ_WE  in  1  1 = write, 0 = read
- BUS_REQ_ADDR  in  ADDR_W  byte address, passed unmodified
- BUS_REQ_WDATA  in  DATA_W  write data
- BUS_REQ_WSTB  in  DATA_W/8  byte strobes
- BUS_RSP_VALID  out  1  response available
- BUS_RSP_READY  in  1  response consumed
- BUS_RSP_WE  out  1  response belongs to a write
- BUS_RSP_RDATA  out  DATA_W  read data; 0 for writes
- BUS_RSP_RESP  out  2  BRESP/RRESP, or 2'b11 on timeout
- BUS_LEVEL  out  $clog2(DEPTH+1)  FIFO occupancy
- BUS_TIMEOUT  out  1  sticky watchdog flag

## Operation
- Push when BUS_REQ_VALID && BUS_REQ_READY. BUS_REQ_READY = (BUS_LEVEL < DEPTH); no pass-through when full, even with a simultaneous pop. Push and pop in the same cycle leave the level unchanged.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE: if the FIFO is non-empty, pop the head. Write -> WR_AW_W; read -> RD_AR.
- WR_AW_W: AWVALID and WVALID rise together. Each drops independently on its own handshake; AW and W may complete in either order or the same cycle. When both are done -> WR_B.
- WR_B: BREADY=1. On BVALID -> RSP; capture BRESP, RDATA field = 0, WE=1.
- RD_AR: ARVALID=1 until ARREADY -> RD_R.
- RD_R: RREADY=1. On RVALID -> RSP; capture RDATA/RRESP, WE=0.
- RSP: BUS_RSP_VALID=1 and the payload is held stable until BUS_RSP_READY, then -> IDLE.
- Only one AXI transaction is outstanding at a time. AXI VALIDs never drop before their handshake. Payload outputs do not change while VALID is high.
- Reset values: every VALID/READY output, BUS_RSP_*, BUS_LEVEL and BUS_TIMEOUT are 0; address/data outputs are 0; FSM=IDLE; FIFO empty.
- Reset mid-transaction: the in-flight transaction and queued entries are discarded, and all VALIDs are low after the reset edge. The slave is expected to be reset with the block.

## Timing
- A request pushed at edge N asserts AW/W/ARVALID after edge N+1, when the FIFO was empty and the FSM was in IDLE.
- A B/R handshake at edge M makes BUS_RSP_VALID high after edge M.
- A BUS_RSP_READY handshake at edge P puts the FSM in IDLE after P; the next command's VALID is high after P+1.
- Minimum read round trip with zero-wait slave (ARREADY and RVALID each high in the first cycle their channel is active): push N -> BUS_RSP_VALID after N+3.
- BUS_LEVEL updates on the push/pop edge.

## Configuration
- AXIL_MASTER_TIMEOUT_EN defined: a counter clears on entry to WR_B/RD_R and increments each cycle there.
  - When it reaches TIMEOUT_CYC: go to RSP with RESP=2'b11 and RDATA=0, set BUS_TIMEOUT (cleared only by ARESET), and set orphan_b or orphan_r.
  - While an orphan flag is set, the matching BREADY/RREADY stays 1. The next handshake on that channel is discarded and clears the flag.
  - A new transaction of the same type is not issued from IDLE while its orphan flag is set.
- Undefined: no counter or orphan logic; the block waits indefinitely for a response; BUS_TIMEOUT is tied 0.

## Test plan
- Single write 0x10/0xDEADBEEF/WSTB=0xF, zero-wait slave, BRESP=0 -> one AW+W pair, BUS_RSP_VALID with WE=1, RESP=0, RDATA=0.
- Read 0x20, slave returns RDATA=0x12345678 and RRESP=2'b10 after 5-cycle ARREADY stall -> ARVALID held for 6 cycles, response RDATA=0x12345678, RESP=2.
- Skewed AW/W ready: WREADY at cycle 1, AWREADY at cycle 4 -> WVALID drops after cycle 1, AWVALID after cycle 4, exactly one B accepted.
- Push DEPTH+1 back-to-back requests with BUS_RSP_READY=0 -> BUS_REQ_READY low at BUS_LEVEL=DEPTH; releasing it drains in order with correct addresses.
- ARESET asserted in WR_B with 2 queued entries -> all outputs at reset values next cycle, BUS_LEVEL=0.
- TIMEOUT_EN, TIMEOUT_CYC=8, slave withholds RVALID -> RESP=2'b11 at cycle 8, BUS_TIMEOUT=1. A later RVALID is absorbed and the next read is held until then.

Source files
------------

// File: rtl/axil_master_q.sv
// axil_master_q: AXI4-Lite master bridge fed by a DEPTH-entry local request queue.
// Define AXIL_MASTER_TIMEOUT_EN to enable the response watchdog and orphan-response absorption.
module axil_master_q #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [2:0]  PROT        = 3'b000
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  output logic [ADDR_W-1:0]          AWADDR,
  output logic [2:0]                 AWPROT,
  output logic                       AWVALID,
  input  logic                       AWREADY,
  output logic [DATA_W-1:0]          WDATA,
  output logic [DATA_W/8-1:0]        WSTRB,
  output logic                       WVALID,
  input  logic                       WREADY,
  input  logic                       BVALID,
  input  logic [1:0]                 BRESP,
  output logic                       BREADY,
  output logic [ADDR_W-1:0]          ARADDR,
  output logic [2:0]                 ARPROT,
  output logic                       ARVALID,
  input  logic                       ARREADY,
  input  logic [DATA_W-1:0]          RDATA,
  input  logic [1:0]                 RRESP,
  input  logic                       RVALID,
  output logic                       RREADY,
  input  logic                       BUS_REQ_VALID,
  output logic                       BUS_REQ_READY,
  input  logic                       BUS_REQ_WE,
  input  logic [ADDR_W-1:0]          BUS_REQ_ADDR,
  input  logic [DATA_W-1:0]          BUS_REQ_WDATA,
  input  logic [DATA_W/8-1:0]        BUS_REQ_WSTB,
  output logic                       BUS_RSP_VALID,
  input  logic                       BUS_RSP_READY,
  output logic                       BUS_RSP_WE,
  output logic [DATA_W-1:0]          BUS_RSP_RDATA,
  output logic [1:0]                 BUS_RSP_RESP,
  output logic [$clog2(DEPTH+1)-1:0] BUS_LEVEL,
  output logic                       BUS_TIMEOUT
);
  localparam int unsigned STB_W = DATA_W / 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STB_W-1:0]  wstb;
  } req_t;

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

  // Reject unsupported configurations at elaboration
  if ((DATA_W != 32 && DATA_W != 64) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1)
  begin : g_bad_param
    $error("axil_master_q: unsupported parameter set");
  end

  req_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  state_t           state;
  req_t             head;
  logic             push;
  logic             pop;
  logic             head_blocked;
  logic [LVL_W-1:0] level_nxt;

  assign AWPROT    = PROT;
  assign ARPROT    = PROT;
  assign head      = fifo_mem[rd_ptr];
  assign push      = BUS_REQ_VALID && BUS_REQ_READY;
  assign pop       = (state == IDLE) && (BUS_LEVEL != '0) && !head_blocked;
  assign level_nxt = BUS_LEVEL + LVL_W'(push) - LVL_W'(pop);

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             orphan_b;
  logic             orphan_r;
  logic             wd_expired;

  assign wd_expired   = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
  // A late response for a timed-out transaction must drain before reusing that channel
  assign head_blocked = head.we ? orphan_b : orphan_r;
`else
  assign head_blocked = 1'b0;
  assign BUS_TIMEOUT  = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (push) fifo_mem[wr_ptr] <= '{BUS_REQ_WE, BUS_REQ_ADDR, BUS_REQ_WDATA, BUS_REQ_WSTB};
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      BUS_LEVEL     <= '0;
      BUS_REQ_READY <= 1'b0;
      AWADDR        <= '0;
      AWVALID       <= 1'b0;
      WDATA         <= '0;
      WSTRB         <= '0;
      WVALID        <= 1'b0;
      BREADY        <= 1'b0;
      ARADDR        <= '0;
      ARVALID       <= 1'b0;
      RREADY        <= 1'b0;
      BUS_RSP_VALID <= 1'b0;
      BUS_RSP_WE    <= 1'b0;
      BUS_RSP_RDATA <= '0;
      BUS_RSP_RESP  <= '0;
`ifdef AXIL_MASTER_TIMEOUT_EN
      wd_cnt        <= '0;
      orphan_b      <= 1'b0;
      orphan_r      <= 1'b0;
      BUS_TIMEOUT   <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      BUS_LEVEL     <= level_nxt;
      BUS_REQ_READY <= (level_nxt < LVL_W'(DEPTH));

`ifdef AXIL_MASTER_TIMEOUT_EN
      // Swallow the first late response on an orphaned channel
      if (orphan_b && BVALID) begin
        orphan_b <= 1'b0;
        BREADY   <= 1'b0;
      end
      if (orphan_r && RVALID) begin
        orphan_r <= 1'b0;
        RREADY   <= 1'b0;
      end
`endif

      case (state)
        IDLE: begin
          if (pop) begin
            if (head.we) begin
              AWADDR  <= head.addr;
              WDATA   <= head.wdata;
              WSTRB   <= head.wstb;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= WR_AW_W;
            end else begin
              ARADDR  <= head.addr;
              ARVALID <= 1'b1;
              state   <= RD_AR;
            end
          end
        end
        WR_AW_W: begin
          if (AWREADY) AWVALID <= 1'b0;
          if (WREADY)  WVALID  <= 1'b0;
          if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
            BREADY <= 1'b1;
            state  <= WR_B;
`ifdef AXIL_MASTER_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        WR_B: begin
          if (BVALID) begin
            BREADY        <= 1'b0;
            BUS_RSP_VALID <= 1'b1;
            BUS_RSP_WE    <= 1'b1;
            BUS_RSP_RDATA <= '0;
            BUS_RSP_RESP  <= BRESP;
            state         <= RSP;
          end
`ifdef AXIL_MASTER_TIMEOUT_EN
          else if (wd_expired) begin
            orphan_b      <= 1'b1;
            BUS_TIMEOUT   <= 1'b1;
            BUS_RSP_VALID <= 1'b1;
            BUS_RSP_WE    <= 1'b1;
            BUS_RSP_RDATA <= '0;
            BUS_RSP_RESP  <= 2'b11;
            state         <= RSP;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
`endif
        end
        RD_AR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD_R;
`ifdef AXIL_MASTER_TIMEOUT_EN
            wd_cnt  <= '0;
`endif
          end
        end
        RD_R: begin
          if (RVALID) begin
            RREADY        <= 1'b0;
            BUS_RSP_VALID <= 1'b1;
            BUS_RSP_WE    <= 1'b0;
            BUS_RSP_RDATA <= RDATA;
            BUS_RSP_RESP  <= RRESP;
            state         <= RSP;
          end
`ifdef AXIL_MASTER_TIMEOUT_EN
          else if (wd_expired) begin
            orphan_r      <= 1'b1;
            BUS_TIMEOUT   <= 1'b1;
            BUS_RSP_VALID <= 1'b1;
            BUS_RSP_WE    <= 1'b0;
            BUS_RSP_RDATA <= '0;
            BUS_RSP_RESP  <= 2'b11;
            state         <= RSP;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
`endif
        end
        RSP: begin
          if (BUS_RSP_READY) begin
            BUS_RSP_VALID <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_master_q.sv
// tb_axil_master_q: table-driven vectors with a scripted AXI4-Lite slave and a response scoreboard.
module tb_axil_master_q;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    int          aw_wait;
    int          w_wait;
    int          ar_wait;
    int          rsp_wait;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } rsp_t;

  logic        ACLK, ARESET;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [1:0]  BRESP, RRESP;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic        BUS_REQ_VALID, BUS_REQ_READY, BUS_REQ_WE;
  logic [31:0] BUS_REQ_ADDR, BUS_REQ_WDATA, BUS_RSP_RDATA;
  logic [3:0]  BUS_REQ_WSTB;
  logic        BUS_RSP_VALID, BUS_RSP_READY, BUS_RSP_WE;
  logic [1:0]  BUS_RSP_RESP;
  logic [2:0]  BUS_LEVEL;
  logic        BUS_TIMEOUT;

  vec_t slave_q[$];
  rsp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  axil_master_q #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT_CYC(8), .PROT(3'b010)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .BUS_REQ_VALID(BUS_REQ_VALID), .BUS_REQ_READY(BUS_REQ_READY), .BUS_REQ_WE(BUS_REQ_WE),
    .BUS_REQ_ADDR(BUS_REQ_ADDR), .BUS_REQ_WDATA(BUS_REQ_WDATA), .BUS_REQ_WSTB(BUS_REQ_WSTB),
    .BUS_RSP_VALID(BUS_RSP_VALID), .BUS_RSP_READY(BUS_RSP_READY), .BUS_RSP_WE(BUS_RSP_WE),
    .BUS_RSP_RDATA(BUS_RSP_RDATA), .BUS_RSP_RESP(BUS_RSP_RESP),
    .BUS_LEVEL(BUS_LEVEL), .BUS_TIMEOUT(BUS_TIMEOUT)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Nothing new may be issued while the slave is producing a response
  task automatic idle_chk();
    chk("no_issue_while_busy", 32'(AWVALID | WVALID | ARVALID), 32'(0));
  endtask

  task automatic slave_write();
    vec_t t;
    bit   aw_done = 1'b0;
    bit   w_done  = 1'b0;
    int   cyc     = 0;
    if (slave_q.size() == 0) begin
      fail_now("unexpected_write_issue");
      return;
    end
    t = slave_q.pop_front();
    while (!(aw_done && w_done)) begin
      chk("awvalid_hold", 32'(AWVALID), 32'(!aw_done));
      chk("wvalid_hold", 32'(WVALID), 32'(!w_done));
      if (!aw_done) chk("awaddr", AWADDR, t.addr);
      if (!w_done) begin
        chk("wdata", WDATA, t.wdata);
        chk("wstrb", 32'(WSTRB), 32'(t.wstb));
      end
      AWREADY = !aw_done && (cyc >= t.aw_wait);
      WREADY  = !w_done && (cyc >= t.w_wait);
      aw_done = aw_done | AWREADY;
      w_done  = w_done | WREADY;
      @(negedge ACLK);
      cyc++;
      AWREADY = 1'b0;
      WREADY  = 1'b0;
      if (ARESET) return;
      if (cyc > 100) begin
        fail_now("aw_w_phase_budget");
        return;
      end
    end
    chk("bready_on_entry", 32'(BREADY), 32'(1));
    for (int i = 0; i < t.rsp_wait; i++) begin
      idle_chk();
      @(negedge ACLK);
      if (ARESET) return;
    end
    BVALID = 1'b1;
    BRESP  = t.s_resp;
    @(negedge ACLK);
    BVALID = 1'b0;
    BRESP  = 2'b00;
    chk("bready_after_b", 32'(BREADY), 32'(0));
  endtask

  task automatic slave_read();
    vec_t t;
    bit   done = 1'b0;
    int   cyc  = 0;
    if (slave_q.size() == 0) begin
      fail_now("unexpected_read_issue");
      return;
    end
    t = slave_q.pop_front();
    while (!done) begin
      chk("arvalid_hold", 32'(ARVALID), 32'(1));
      chk("araddr", ARADDR, t.addr);
      chk("arprot", 32'(ARPROT), 32'(3'b010));
      ARREADY = (cyc >= t.ar_wait);
      done    = ARREADY;
      @(negedge ACLK);
      cyc++;
      ARREADY = 1'b0;
      if (ARESET) return;
      if (cyc > 100) begin
        fail_now("ar_phase_budget");
        return;
      end
    end
    chk("rready_on_entry", 32'(RREADY), 32'(1));
    for (int i = 0; i < t.rsp_wait; i++) begin
      idle_chk();
      @(negedge ACLK);
      if (ARESET) return;
    end
    RVALID = 1'b1;
    RDATA  = t.s_rdata;
    RRESP  = t.s_resp;
    @(negedge ACLK);
    RVALID = 1'b0;
    RDATA  = '0;
    RRESP  = 2'b00;
    chk("rready_after_r", 32'(RREADY), 32'(0));
  endtask

  // Scripted slave: serves one transaction at a time in issue order
  initial begin
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
    forever begin
      @(negedge ACLK);
      if (!ARESET && (AWVALID || WVALID)) slave_write();
      else if (!ARESET && ARVALID) slave_read();
    end
  end

  // Scoreboard: compare each accepted response against the oldest expectation
  initial begin
    rsp_t e;
    forever begin
      @(negedge ACLK);
      #1;
      if (!ARESET && BUS_RSP_VALID && BUS_RSP_READY) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_response");
        end else begin
          e = exp_q.pop_front();
          chk("rsp_we", 32'(BUS_RSP_WE), 32'(e.we));
          chk("rsp_rdata", BUS_RSP_RDATA, e.rdata);
          chk("rsp_resp", 32'(BUS_RSP_RESP), 32'(e.resp));
        end
      end
    end
  end

  task automatic push_req(input vec_t v, input bit track);
    int n = 0;
    BUS_REQ_WE    = v.we;
    BUS_REQ_ADDR  = v.addr;
    BUS_REQ_WDATA = v.wdata;
    BUS_REQ_WSTB  = v.wstb;
    BUS_REQ_VALID = 1'b1;
    while (!BUS_REQ_READY && n < 300) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 300) fail_now("req_ready_budget");
    if (track) begin
      slave_q.push_back(v);
      exp_q.push_back('{v.we, v.exp_rdata, v.exp_resp});
    end
    @(negedge ACLK);
    BUS_REQ_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || slave_q.size() != 0) && n < 400) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 400) fail_now("drain_budget");
    repeat (2) @(negedge ACLK);
  endtask

  task automatic wait_req_ready();
    int n = 0;
    while (!BUS_REQ_READY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("req_ready_after_reset", 32'(BUS_REQ_READY), 32'(1));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_awvalid", 32'(AWVALID), 32'(0));
    chk("rst_wvalid", 32'(WVALID), 32'(0));
    chk("rst_bready", 32'(BREADY), 32'(0));
    chk("rst_arvalid", 32'(ARVALID), 32'(0));
    chk("rst_rready", 32'(RREADY), 32'(0));
    chk("rst_req_ready", 32'(BUS_REQ_READY), 32'(0));
    chk("rst_rsp_valid", 32'(BUS_RSP_VALID), 32'(0));
    chk("rst_rsp_we", 32'(BUS_RSP_WE), 32'(0));
    chk("rst_rsp_rdata", BUS_RSP_RDATA, 32'(0));
    chk("rst_rsp_resp", 32'(BUS_RSP_RESP), 32'(0));
    chk("rst_level", 32'(BUS_LEVEL), 32'(0));
    chk("rst_timeout", 32'(BUS_TIMEOUT), 32'(0));
    chk("rst_awaddr", AWADDR, 32'(0));
    chk("rst_araddr", ARADDR, 32'(0));
    chk("rst_wdata", WDATA, 32'(0));
    chk("rst_wstrb", 32'(WSTRB), 32'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    vec_t v;
    int   k;
    int   ar_k;

    //        we    addr            wdata          wstb  aw w  ar rsp s_rdata        s_resp exp_rdata      exp_resp
    tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 32'h0,         2'b00, 32'h0,         2'b00};
    tbl[1] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 0, 5, 0, 32'h1234_5678, 2'b10, 32'h1234_5678, 2'b10};
    tbl[2] = '{1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'h3, 4, 1, 0, 2, 32'h0,         2'b01, 32'h0,         2'b01};
    tbl[3] = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 0, 0, 0, 0, 32'hA5A5_5A5A, 2'b00, 32'hA5A5_5A5A, 2'b00};
    tbl[4] = '{1'b1, 32'h0000_0100, 32'h0BAD_F00D, 4'hC, 0, 3, 0, 1, 32'h0,         2'b10, 32'h0,         2'b10};
    tbl[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 0, 0, 2, 3, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFF, 2'b11};

    ARESET = 1'b1;
    BUS_REQ_VALID = 1'b0; BUS_REQ_WE = 1'b0; BUS_REQ_ADDR = '0;
    BUS_REQ_WDATA = '0; BUS_REQ_WSTB = '0; BUS_RSP_READY = 1'b0;
    repeat (3) @(negedge ACLK);
    chk_reset_outputs();
    chk("awprot_const", 32'(AWPROT), 32'(3'b010));
    ARESET = 1'b0;
    wait_req_ready();

    // Table-driven transactions, one at a time
    BUS_RSP_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_req(tbl[i], 1'b1);
      wait_drain();
    end

    // Zero-wait read latency: ARVALID one edge after the push, response three edges after
    v = tbl[3];
    slave_q.push_back(v);
    exp_q.push_back('{v.we, v.exp_rdata, v.exp_resp});
    BUS_REQ_WE = 1'b0; BUS_REQ_ADDR = v.addr; BUS_REQ_VALID = 1'b1;
    chk("req_ready_idle", 32'(BUS_REQ_READY), 32'(1));
    @(negedge ACLK);
    BUS_REQ_VALID = 1'b0;
    k = 0;
    ar_k = -1;
    while (!BUS_RSP_VALID && k < 20) begin
      if (ARVALID && ar_k < 0) ar_k = k;
      @(negedge ACLK);
      k++;
    end
    chk("ar_latency", 32'(ar_k), 32'(1));
    chk("rd_round_trip", 32'(k), 32'(3));
    wait_drain();

    // Next command issues one edge after the response handshake edge
    BUS_RSP_READY = 1'b0;
    push_req('{1'b0, 32'h180, 32'h0, 4'h0, 0, 0, 0, 0, 32'h1111_0000, 2'b00, 32'h1111_0000, 2'b00}, 1'b1);
    push_req('{1'b0, 32'h184, 32'h0, 4'h0, 0, 0, 0, 0, 32'h2222_0000, 2'b01, 32'h2222_0000, 2'b01}, 1'b1);
    k = 0;
    while (!BUS_RSP_VALID && k < 20) begin
      @(negedge ACLK);
      k++;
    end
    BUS_RSP_READY = 1'b1;
    @(negedge ACLK);
    chk("rsp_valid_after_hs", 32'(BUS_RSP_VALID), 32'(0));
    chk("arvalid_idle_gap", 32'(ARVALID), 32'(0));
    @(negedge ACLK);
    chk("arvalid_next_cmd", 32'(ARVALID), 32'(1));
    wait_drain();

    // Fill the queue while responses are held off
    BUS_RSP_READY = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = '{1'b0, 32'(32'h200 + 4 * i), 32'h0, 4'h0, 0, 0, 0, 0,
            32'(32'h1000 + i), 2'(i), 32'(32'h1000 + i), 2'(i)};
      push_req(v, 1'b1);
    end
    chk("full_level", 32'(BUS_LEVEL), 32'(DEPTH));
    chk("full_req_ready", 32'(BUS_REQ_READY), 32'(0));
    BUS_REQ_VALID = 1'b1;
    BUS_REQ_WE = 1'b0;
    BUS_REQ_ADDR = 32'h0000_0DEA;
    repeat (3) begin
      @(negedge ACLK);
      chk("full_no_push", 32'(BUS_LEVEL), 32'(DEPTH));
    end
    BUS_REQ_VALID = 1'b0;
    chk("full_rsp_pending", 32'(BUS_RSP_VALID), 32'(1));
    BUS_RSP_READY = 1'b1;
    wait_drain();
    chk("drained_level", 32'(BUS_LEVEL), 32'(0));

    // Reset while waiting for B with two entries queued
    push_req('{1'b1, 32'h300, 32'h5555_AAAA, 4'hF, 0, 0, 0, 50, 32'h0, 2'b00, 32'h0, 2'b00}, 1'b1);
    push_req('{1'b0, 32'h304, 32'h0, 4'h0, 0, 0, 0, 0, 32'h0, 2'b00, 32'h0, 2'b00}, 1'b0);
    push_req('{1'b0, 32'h308, 32'h0, 4'h0, 0, 0, 0, 0, 32'h0, 2'b00, 32'h0, 2'b00}, 1'b0);
    k = 0;
    while (!(BREADY && BUS_LEVEL == 3'd2) && k < 20) begin
      @(negedge ACLK);
      k++;
    end
    chk("wr_b_bready", 32'(BREADY), 32'(1));
    chk("wr_b_level", 32'(BUS_LEVEL), 32'(2));
    ARESET = 1'b1;
    @(negedge ACLK);
    chk_reset_outputs();
    slave_q.delete();
    exp_q.delete();
    @(negedge ACLK);
    ARESET = 1'b0;
    wait_req_ready();
    push_req(tbl[0], 1'b1);
    wait_drain();
    chk("post_reset_level", 32'(BUS_LEVEL), 32'(0));

`ifdef AXIL_MASTER_TIMEOUT_EN
    // Withheld RVALID: watchdog response, orphan absorbs the late beat and holds the next read
    BUS_RSP_READY = 1'b0;
    push_req('{1'b0, 32'h400, 32'h0, 4'h0, 0, 0, 0, 20, 32'h7777_7777, 2'b00, 32'h0, 2'b11}, 1'b1);
    push_req('{1'b0, 32'h404, 32'h0, 4'h0, 0, 0, 0, 0, 32'h55AA_55AA, 2'b00, 32'h55AA_55AA, 2'b00}, 1'b1);
    k = 0;
    while (!RREADY && k < 20) begin
      @(negedge ACLK);
      k++;
    end
    k = 0;
    while (!BUS_RSP_VALID && k < 40) begin
      @(negedge ACLK);
      k++;
    end
    chk("timeout_cycles", 32'(k), 32'(8));
    chk("timeout_flag", 32'(BUS_TIMEOUT), 32'(1));
    chk("orphan_rready", 32'(RREADY), 32'(1));
    BUS_RSP_READY = 1'b1;
    wait_drain();
    chk("timeout_sticky", 32'(BUS_TIMEOUT), 32'(1));
    chk("orphan_cleared", 32'(RREADY), 32'(0));
`else
    chk("timeout_tied_low", 32'(BUS_TIMEOUT), 32'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
